// File: rtl/matrix_fb_ctrl.sv
// Write-side controller for the double-buffered LED frame store: arbitrates host
// pixel writes, a back-buffer clear engine and front/back swap requests.
module matrix_fb_ctrl #(
  parameter logic [11:0] CLEAR_VALUE = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        host_req_i,
  input  logic [12:0] host_addr_i,
  input  logic [11:0] host_data_i,
  output logic        host_ack_o,
  input  logic        clear_req_i,
  output logic        clear_busy_o,
  input  logic        swap_req_i,
  output logic        swap_pending_o,
  output logic        swap_done_o,
  input  logic        buffer_current_i,
  output logic        buffer_select_o,
  output logic        wr_o,
  output logic [13:0] wr_addr_o,
  output logic [11:0] wr_data_o
);

  localparam int DATA_W = 12;
  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CLEAR     = 2'd1,
    S_SWAP_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clear_q, clear_d;
  logic                swap_q, swap_d;
  logic                sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                ack_q, ack_d;
  logic                done_q, done_d;
  logic                start_clear;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      clear_q   <= 1'b0;
      swap_q    <= 1'b0;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clear_q   <= clear_d;
      swap_q    <= swap_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear_d     = clear_q;
    swap_d      = swap_q;
    sel_d       = sel_q;
    wr_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ack_d       = 1'b0;
    done_d      = 1'b0;
    start_clear = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clear_q) begin
          // First clear write goes out on the entry edge, so the counter starts at 1.
          start_clear = 1'b1;
          state_d     = S_CLEAR;
          wr_d        = 1'b1;
          wr_addr_d   = {~sel_q, {ADDR_W{1'b0}}};
          wr_data_d   = CLEAR_VALUE;
          cnt_d       = {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (swap_q) begin
          sel_d   = ~sel_q;
          swap_d  = 1'b0;
          state_d = S_SWAP_WAIT;
        end else if (host_req_i && !ack_q) begin
          wr_d      = 1'b1;
          wr_addr_d = {~sel_q, host_addr_i};
          wr_data_d = host_data_i;
          ack_d     = 1'b1;
        end
      end
      S_CLEAR: begin
        // Counter wraps to 0 after the write to the last address.
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          wr_d      = 1'b1;
          wr_addr_d = {~sel_q, cnt_q};
          wr_data_d = CLEAR_VALUE;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      S_SWAP_WAIT: begin
        if (buffer_current_i == sel_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_clear) begin
      clear_d = 1'b0;
    end
    if (clear_req_i && (state_q != S_CLEAR) && !start_clear) begin
      clear_d = 1'b1;
    end
    if (swap_req_i && !swap_q && (state_q != S_SWAP_WAIT)) begin
      swap_d = 1'b1;
    end
  end

  assign host_ack_o      = ack_q;
  assign clear_busy_o    = clear_q || (state_q == S_CLEAR);
  assign swap_pending_o  = swap_q || (state_q == S_SWAP_WAIT);
  assign swap_done_o     = done_q;
  assign buffer_select_o = sel_q;
  assign wr_o            = wr_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_data_o       = wr_data_q;

endmodule

// File: doc/matrix_fb_ctrl.md
# matrix_fb_ctrl

Write-side controller for the double-buffered 64-row LED panel frame store. It sits between the host write path and the matrix driver's write port, and arbitrates three sources of work:
- single-pixel host writes;
- a built-in back-buffer clear engine;
- buffer-swap requests.

It owns `buffer_select`, always directs writes to the back buffer, and blocks writes until the driver has actually switched to the new front buffer.

## Interface
Parameters:
- `CLEAR_VALUE`, default 12'h000: pixel word written by the clear engine.

Ports:
- `clk` in 1: single clock, shared with the matrix driver's `clk` and `wr_clk`.
- `rst` in 1: synchronous, active-high reset.
- `host_req` in 1: level; host write request, held until `host_ack`.
- `host_addr` in 13: pixel address within a buffer, laid out as {RAM select, column bit 7, row[3:0], column[6:0]}.
- `host_data` in 12: pixel word {r,g,b} for one RAM.
- `host_ack` out 1: one-cycle pulse; the request was written this cycle.
- `clear_req` in 1: pulse; request a clear of the back buffer.
- `clear_busy` out 1: a clear is pending or in progress.
- `swap_req` in 1: pulse; request a front/back swap.
- `swap_pending` out 1: a swap is requested and not yet complete.
- `swap_done` out 1: one-cycle pulse; the driver is now displaying the new buffer.
- `buffer_current` in 1: buffer the driver is currently displaying.
- `buffer_select` out 1: requested front buffer.
- `wr` out 1: write strobe to the matrix.
- `wr_addr` out 14: {back buffer, 13-bit address}.
- `wr_data` out 12: write data.

## Operation
- Back buffer is `~buffer_select`. Every write uses `wr_addr[13] = ~buffer_select`.
- `clear_req` and `swap_req` are latched into pending flags on the edge they are sampled high.
  - A `swap_req` while a swap is already pending is ignored.
  - A `clear_req` during CLEAR is ignored.
  - A `clear_req` during SWAP_WAIT is latched; the clear then runs on the new back buffer.
- State machine has three states: IDLE, CLEAR and SWAP_WAIT.
- IDLE arbitrates with fixed priority: clear pending, then swap pending, then `host_req`.
  - Clear pending: go to CLEAR. On the same edge, issue the write to address 0 and set the counter to 1.
  - Swap pending: toggle `buffer_select`, clear the swap flag, go to SWAP_WAIT.
  - `host_req` high and `host_ack` low: register `wr`=1, `wr_addr`={back, `host_addr`}, `wr_data`=`host_data`, `host_ack`=1.
  - `host_req` is ignored in any cycle where `host_ack` is high. This prevents a double write; peak host rate is one write per 2 cycles.
- CLEAR:
  - One write per cycle: `wr`=1, `wr_addr`={back, counter}, `wr_data`=`CLEAR_VALUE`.
  - The 13-bit counter runs from 0 to 8191, giving 8192 consecutive writes.
  - After the write to 8191, `wr` drops and the state returns to IDLE.
  - `host_req` is not acked.
- SWAP_WAIT:
  - No writes. The new back buffer is still on display.
  - Each cycle, compare `buffer_current` with `buffer_select`. When they are equal, pulse `swap_done` for one cycle and return to IDLE.
  - There is no timeout. The wait lasts up to one driver frame.
- `wr` is 0 in every cycle that does not carry a write.
- `wr_addr` and `wr_data` hold their last value when `wr` is 0.

## Timing
- Reset values: `buffer_select`=0, `wr`=0, `wr_addr`=0, `wr_data`=0, `host_ack`=0, `clear_busy`=0, `swap_pending`=0, `swap_done`=0. State is IDLE, flags and counter are 0.
- Reset at any time, including mid-clear or mid-swap-wait, aborts immediately. No further writes occur.
- Host write: `host_req` sampled high in IDLE at edge N. Then `wr` and `host_ack` are high in cycle N+1, and low in N+2 at the earliest.
- Clear:
  - `clear_req` is sampled at edge N; `clear_busy` is high from N+1.
  - Writes occur in cycles N+2 through N+8193.
  - `clear_busy` is low from N+8194, provided no other clear is latched.
- Swap:
  - `swap_req` is sampled at edge N; `swap_pending` is high from N+1.
  - `buffer_select` toggles at N+2 (from IDLE).
  - `swap_done` pulses in the cycle after `buffer_current` first matches. `swap_pending` falls together with that pulse.
- Simultaneous `clear_req` and `swap_req`: the clear runs first, then the swap, so the freshly cleared buffer is shown.
- Simultaneous pending work and `host_req`: the host waits, with `host_ack` held low.

## Test plan
- Reset, then `host_req` with addr 0x0123 and data 0xABC → one-cycle `wr` with `wr_addr`=0x2123, `wr_data`=0xABC, `host_ack` in the same cycle. Host holding `host_req` high across 4 transactions → writes every 2nd cycle, never a duplicate.
- `clear_req` pulse → exactly 8192 `wr` cycles with addresses 0x2000..0x3FFF and data 0x000. `clear_busy` high for exactly 8193 cycles. A `host_req` during the clear is acked only after it finishes.
- `swap_req` with the model holding `buffer_current`=0 for 500 cycles, then 1 → `buffer_select`=1 two cycles after the request. No `wr` during the wait. `swap_done` pulses once, the cycle after the change. The next host write uses `wr_addr[13]`=0.
- `clear_req` and `swap_req` in the same cycle → full clear of buffer 1 completes before `buffer_select` toggles. Then `swap_done`.
- `rst` asserted at clear write 4000 → `wr`=0 from the next cycle and all outputs return to reset values. A new `clear_req` restarts at address 0.
- Second `swap_req` during SWAP_WAIT → ignored: a single toggle and a single `swap_done`.
